// File: rtl/nodf_module_intf_pkg.sv
// Shared types and defaults for the ap_ctrl transaction monitor.
package nodf_module_intf_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_CONT = 2'd2,
    ST_FROZEN    = 2'd3
  } state_t;

endpackage

// File: rtl/nodf_module_intf_if.sv
// Handshake inputs and statistics outputs of the ap_ctrl monitor.
interface nodf_module_intf_if
  import nodf_module_intf_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);

  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             finish;

  state_t           state;
  logic [CNT_W-1:0] start_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] last_lat;
  logic [CNT_W-1:0] min_lat;
  logic [CNT_W-1:0] max_lat;
  logic [CNT_W-1:0] last_ii;
  logic             err_done_idle;

  // Environment side: drives the handshake, observes the statistics.
  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish,
    input  state, start_cnt, done_cnt, last_lat, min_lat, max_lat,
           last_ii, err_done_idle
  );

  // Monitor side: ap_ready is carried for the record but takes no part in
  // transaction tracking.
  modport slave (
    input  ap_start, ap_done, ap_continue, finish,
    output state, start_cnt, done_cnt, last_lat, min_lat, max_lat,
           last_ii, err_done_idle
  );

endinterface

// File: rtl/nodf_module_intf_sat_counter.sv
// Saturating counter with synchronous load (priority) and increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Load wins over increment; increment sticks at all ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/nodf_module_intf.sv
// ap_ctrl_chain transaction monitor: counts starts/dones, measures latency
// and start-to-start interval, flags done-while-idle, freezes on finish.
module nodf_module_intf
  import nodf_module_intf_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  nodf_module_intf_if.slave   bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] start_cnt_q, done_cnt_q, last_lat_q, min_lat_q;
  logic [CNT_W-1:0] max_lat_q, last_ii_q;
  logic             err_q;
  logic             ii_run_q;

  logic [CNT_W-1:0] lat_q, ii_q, lat_rec;
  logic             accept, done_ev, cont_ev, err_ev, frozen;
  logic             lat_inc, ii_inc;

  // Event decode and next state; finish overrides every other event.
  always_comb begin
    frozen  = (state_q == ST_FROZEN) || bus.finish;
    accept  = (state_q == ST_IDLE) && bus.ap_start && !bus.finish;
    done_ev = !bus.finish && bus.ap_done && ((state_q == ST_RUN) || accept);
    cont_ev = !bus.finish && (state_q == ST_WAIT_CONT) && bus.ap_continue;
    err_ev  = !bus.finish && (state_q == ST_IDLE) && bus.ap_done && !bus.ap_start;
    // The done cycle itself is counted, hence the +1 over the running count.
    lat_rec = accept ? CNT_W'(1) : sat_inc(lat_q);
    lat_inc = (state_q == ST_RUN) && !bus.finish;
    ii_inc  = ii_run_q && !frozen;

    state_d = state_q;
    if (bus.finish) begin
      state_d = ST_FROZEN;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (done_ev) state_d = bus.ap_continue ? ST_IDLE : ST_WAIT_CONT;
            else         state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.ap_done) state_d = bus.ap_continue ? ST_IDLE : ST_WAIT_CONT;
        end
        ST_WAIT_CONT: begin
          if (bus.ap_continue) state_d = ST_IDLE;
        end
        ST_FROZEN: state_d = ST_FROZEN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_lat (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (CNT_W'(1)),
    .inc      (lat_inc),
    .q        (lat_q)
  );

  sat_counter #(.W(CNT_W)) u_ii (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val ('0),
    .inc      (ii_inc),
    .q        (ii_q)
  );

  // State register and registered statistics.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      start_cnt_q <= '0;
      done_cnt_q  <= '0;
      last_lat_q  <= '0;
      min_lat_q   <= '1;
      max_lat_q   <= '0;
      last_ii_q   <= '0;
      err_q       <= 1'b0;
      ii_run_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        start_cnt_q <= sat_inc(start_cnt_q);
        ii_run_q    <= 1'b1;
        if (ii_run_q) last_ii_q <= sat_inc(ii_q);
      end
      if (done_ev) begin
        last_lat_q <= lat_rec;
        if (lat_rec < min_lat_q) min_lat_q <= lat_rec;
        if (lat_rec > max_lat_q) max_lat_q <= lat_rec;
      end
      if ((done_ev && bus.ap_continue) || cont_ev) begin
        done_cnt_q <= sat_inc(done_cnt_q);
      end
      if (err_ev) err_q <= 1'b1;
    end
  end

  assign bus.state         = state_q;
  assign bus.start_cnt     = start_cnt_q;
  assign bus.done_cnt      = done_cnt_q;
  assign bus.last_lat      = last_lat_q;
  assign bus.min_lat       = min_lat_q;
  assign bus.max_lat       = max_lat_q;
  assign bus.last_ii       = last_ii_q;
  assign bus.err_done_idle = err_q;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Scoreboard bench: stimulus queues the expected output snapshot for each
// observable change; the monitor pops and compares whenever outputs change.
module tb_nodf_module_intf;
  import nodf_module_intf_pkg::*;

  localparam int unsigned W = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  nodf_module_intf_if #(.CNT_W(W)) bus ();

  nodf_module_intf #(.CNT_W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]   st;
    logic [W-1:0] sc, dc, ll, mn, mx, ii;
    logic         er;
  } snap_t;

  snap_t       exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic push(input int st, input int sc, input int dc, input int ll,
                      input int mn, input int mx, input int ii, input int er);
    snap_t s;
    s.st = 2'(st);
    s.sc = W'(sc);
    s.dc = W'(dc);
    s.ll = W'(ll);
    s.mn = W'(mn);
    s.mx = W'(mx);
    s.ii = W'(ii);
    s.er = 1'(er);
    exp_q.push_back(s);
  endtask

  task automatic step(input logic s, input logic d, input logic c, input logic f);
    bus.ap_start    = s;
    bus.ap_done     = d;
    bus.ap_continue = c;
    bus.finish      = f;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Pulse shorter than a clock period: only an asynchronous reset is seen.
  task automatic reset_pulse();
    bus.ap_start = 1'b0;
    bus.ap_done  = 1'b0;
    bus.finish   = 1'b0;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare on every change of the observable outputs.
  initial begin
    snap_t prev, cur, e;
    prev = 'x;
    forever begin
      @(negedge clock);
      cur.st = bus.state;
      cur.sc = bus.start_cnt;
      cur.dc = bus.done_cnt;
      cur.ll = bus.last_lat;
      cur.mn = bus.min_lat;
      cur.mx = bus.max_lat;
      cur.ii = bus.last_ii;
      cur.er = bus.err_done_idle;
      if (cur !== prev) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change t=%0t actual st=%0d sc=%0d dc=%0d ll=%0d mn=%0d mx=%0d ii=%0d er=%0d required no change",
                   $time, cur.st, cur.sc, cur.dc, cur.ll, cur.mn, cur.mx, cur.ii, cur.er);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL snapshot#%0d t=%0t actual st=%0d sc=%0d dc=%0d ll=%0d mn=%0d mx=%0d ii=%0d er=%0d required st=%0d sc=%0d dc=%0d ll=%0d mn=%0d mx=%0d ii=%0d er=%0d",
                     n_tests, $time, cur.st, cur.sc, cur.dc, cur.ll, cur.mn, cur.mx, cur.ii, cur.er,
                     e.st, e.sc, e.dc, e.ll, e.mn, e.mx, e.ii, e.er);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual still running required finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ap_start    = 1'b0;
    bus.ap_ready    = 1'b1;
    bus.ap_done     = 1'b0;
    bus.ap_continue = 1'b1;
    bus.finish      = 1'b0;

    push(0, 0, 0, 0, 15, 0, 0, 0);
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Latency 6: start, 4 run cycles, done
    push(1, 1, 0, 0, 15, 0, 0, 0); step(1, 0, 1, 0);
    idle(4);
    push(0, 1, 1, 6, 6, 6, 0, 0);  step(0, 1, 1, 0);

    // Latencies 4, 2, 7 with back-to-back starts
    push(1, 2, 1, 6, 6, 6, 6, 0);  step(1, 0, 1, 0);
    idle(2);
    push(0, 2, 2, 4, 4, 6, 6, 0);  step(0, 1, 1, 0);
    push(1, 3, 2, 4, 4, 6, 4, 0);  step(1, 0, 1, 0);
    push(0, 3, 3, 2, 2, 6, 4, 0);  step(0, 1, 1, 0);
    push(1, 4, 3, 2, 2, 6, 2, 0);  step(1, 0, 1, 0);
    idle(1);
    step(1, 0, 1, 0);              // start while running: ignored
    idle(3);
    push(0, 4, 4, 7, 2, 7, 2, 0);  step(0, 1, 1, 0);

    // Start and done together, then a second one 10 cycles later
    push(0, 5, 5, 1, 1, 7, 7, 0);  step(1, 1, 1, 0);
    idle(9);
    push(0, 6, 6, 1, 1, 7, 10, 0); step(1, 1, 1, 0);

    // Done with continue low for 3 cycles
    push(1, 7, 6, 1, 1, 7, 1, 0);  step(1, 0, 1, 0);
    push(2, 7, 6, 2, 1, 7, 1, 0);  step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    push(0, 7, 7, 2, 1, 7, 1, 0);  step(0, 0, 1, 0);

    // Done while idle sets the sticky error
    push(0, 7, 7, 2, 1, 7, 1, 1);  step(0, 1, 1, 0);

    // Latency and interval saturate at 15
    push(1, 8, 7, 2, 1, 7, 6, 1);  step(1, 0, 1, 0);
    idle(18);
    push(0, 8, 8, 15, 1, 15, 6, 1);  step(0, 1, 1, 0);
    push(1, 9, 8, 15, 1, 15, 15, 1); step(1, 0, 1, 0);
    push(0, 9, 9, 2, 1, 15, 15, 1);  step(0, 1, 1, 0);

    // Start/done counters saturate at 15
    push(0, 10, 10, 1, 1, 15, 2, 1); step(1, 1, 1, 0);
    for (int k = 11; k <= 15; k++) begin
      push(0, k, k, 1, 1, 15, 1, 1);
      step(1, 1, 1, 0);
    end
    step(1, 1, 1, 0);              // already saturated: no change

    // Finish during run freezes everything, including a simultaneous done
    push(1, 15, 15, 1, 1, 15, 1, 1); step(1, 0, 1, 0);
    idle(1);
    push(3, 15, 15, 1, 1, 15, 1, 1); step(0, 1, 1, 1);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 1);

    // Reset leaves FROZEN and clears the sticky error
    push(0, 0, 0, 0, 15, 0, 0, 0);
    reset_pulse();

    // Reset mid-run discards the transaction
    push(1, 1, 0, 0, 15, 0, 0, 0); step(1, 0, 1, 0);
    idle(2);
    push(0, 0, 0, 0, 15, 0, 0, 0);
    reset_pulse();
    push(1, 1, 0, 0, 15, 0, 0, 0); step(1, 0, 1, 0);
    idle(1);
    push(0, 1, 1, 3, 3, 3, 0, 0);  step(0, 1, 1, 0);

    idle(3);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL pending_expectations actual %0d left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
